ready_valid_join_buffered: RTL

- Rejoins two ready/valid streams, typically the two branches produced by a fork stage, into one combined stream.
- Each input branch has its own small FIFO, so the branches may accept beats at different times and skew by up to DEPTH beats.
- An output beat is emitted only when both FIFOs hold a beat; both heads pop together.
- Sits downstream of a fork in the RAM model path, after two consumers with independent timing, e.g. a timing model and a data path.

---
 rtl/ready_valid_join_buffered.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ready_valid_join_buffered.sv
// Joins two ready/valid branches into one stream. Each branch is decoupled by its own
// FIFO so the branches can skew by up to DEPTH beats; both heads pop together.

module rvjb_branch_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

module ready_valid_join_buffered #(
   parameter int A_WIDTH = 1,
   parameter int B_WIDTH = 1,
   parameter int DEPTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s1_valid,
   input  logic [A_WIDTH-1:0]         s1_data,
   output logic                       s1_ready,
   input  logic                       s2_valid,
   input  logic [B_WIDTH-1:0]         s2_data,
   output logic                       s2_ready,
   output logic                       m_valid,
   output logic [A_WIDTH+B_WIDTH-1:0] m_data,
   input  logic                       m_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end

   logic [CNT_W-1:0]   w_count1;
   logic [CNT_W-1:0]   w_count2;
   logic [A_WIDTH-1:0] w_head1;
   logic [B_WIDTH-1:0] w_head2;
   logic               w_push1;
   logic               w_push2;
   logic               w_pop;

   // Ready comes from registered counts only, so a full FIFO stays closed in its pop cycle.
   assign s1_ready = (w_count1 != FULL_CNT) && !rst;
   assign s2_ready = (w_count2 != FULL_CNT) && !rst;
   assign w_push1  = s1_valid && s1_ready;
   assign w_push2  = s2_valid && s2_ready;

   assign m_valid  = (w_count1 != '0) && (w_count2 != '0);
   assign w_pop    = m_valid && m_ready && !rst;
   assign m_data   = {w_head2, w_head1};

   rvjb_branch_fifo #(
      .WIDTH (A_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push1),
      .i_data  (s1_data),
      .i_pop   (w_pop),
      .o_head  (w_head1),
      .o_count (w_count1)
   );

   rvjb_branch_fifo #(
      .WIDTH (B_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo2 (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push2),
      .i_data  (s2_data),
      .i_pop   (w_pop),
      .o_head  (w_head2),
      .o_count (w_count2)
   );

endmodule
